// File: rtl/conv_row_engine.sv
// One row of a 1-D convolution: serial weight load, sliding KERNEL_SIZE window over
// an IFM row, bias add, and a small output FIFO with valid/ready backpressure.
module conv_row_engine #(
    parameter int KERNEL_SIZE  = 3,
    parameter int IFM_WIDTH    = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int ROW_LEN      = 16,
    parameter int OUT_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    reuse_wgt,
    input  logic                    wgt_valid,
    output logic                    wgt_ready,
    input  logic [WEIGHT_WIDTH-1:0] wgt_in,
    input  logic                    ifm_valid,
    output logic                    ifm_ready,
    input  logic [IFM_WIDTH-1:0]    ifm_in,
    input  logic [DATA_WIDTH-1:0]   psum_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              fsm_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; ready never depends on valid, and out_valid/out_data hold until popped.

    localparam int PW  = IFM_WIDTH + WEIGHT_WIDTH;
    localparam int AW  = $clog2(ROW_LEN + 1);
    localparam int IW  = $clog2(KERNEL_SIZE);
    localparam int PTW = $clog2(OUT_DEPTH);
    localparam int CW  = $clog2(OUT_DEPTH + 1);

    localparam logic [AW-1:0]  ROW_LAST  = AW'(ROW_LEN - 1);
    localparam logic [AW-1:0]  ROW_END   = AW'(ROW_LEN);
    localparam logic [AW-1:0]  FIRST_OUT = AW'(KERNEL_SIZE - 1);
    localparam logic [IW-1:0]  WGT_LAST  = IW'(KERNEL_SIZE - 1);
    localparam logic [PTW-1:0] PTR_LAST  = PTW'(OUT_DEPTH - 1);
    localparam logic [CW:0]    DEPTH_C   = (CW + 1)'(OUT_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_WGT = 2'd1,
        RUN      = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t                  state;
    logic [WEIGHT_WIDTH-1:0] w       [KERNEL_SIZE];
    logic [IFM_WIDTH-1:0]    win     [KERNEL_SIZE];
    logic [IFM_WIDTH-1:0]    new_win [KERNEL_SIZE];
    logic [AW-1:0]           acc_cnt;
    logic [IW-1:0]           wgt_idx;
    logic                    pending;
    logic [DATA_WIDTH-1:0]   pend_data;
    logic [DATA_WIDTH-1:0]   result;
    logic [PW-1:0]           prod;
    logic [DATA_WIDTH-1:0]   mem     [OUT_DEPTH];
    logic [PTW-1:0]          rd_ptr;
    logic [PTW-1:0]          wr_ptr;
    logic [CW-1:0]           count;
    logic [CW:0]             occupancy;
    logic                    ifm_fire;
    logic                    wgt_fire;
    logic                    pop;

    assign busy      = (state != IDLE);
    assign wgt_ready = (state == LOAD_WGT);
    assign fsm_state = state;
    // A registered-but-not-yet-pushed result already owns a FIFO slot.
    assign occupancy = {1'b0, count} + (CW + 1)'(pending);
    assign ifm_ready = (state == RUN) && (acc_cnt < ROW_END) && (occupancy < DEPTH_C);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign ifm_fire  = ifm_valid && ifm_ready;
    assign wgt_fire  = wgt_valid && wgt_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        for (int i = 0; i < KERNEL_SIZE - 1; i++) begin
            new_win[i] = win[i + 1];
        end
        new_win[KERNEL_SIZE - 1] = ifm_in;
    end

    always_comb begin
        result = psum_in;
        prod   = '0;
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            prod   = PW'(w[k]) * PW'(new_win[k]);
            result = result + DATA_WIDTH'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_cnt   <= '0;
            wgt_idx   <= '0;
            pending   <= 1'b0;
            pend_data <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            done      <= 1'b0;
            for (int i = 0; i < KERNEL_SIZE; i++) begin
                w[i]   <= '0;
                win[i] <= '0;
            end
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            pending <= 1'b0;

            if (pending) begin
                mem[wr_ptr] <= pend_data;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTW'(1);
            end
            case ({pending, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (start) begin
                        acc_cnt <= '0;
                        wgt_idx <= '0;
                        for (int i = 0; i < KERNEL_SIZE; i++) begin
                            win[i] <= '0;
                        end
                        state <= reuse_wgt ? RUN : LOAD_WGT;
                    end
                end
                LOAD_WGT: begin
                    if (wgt_fire) begin
                        w[wgt_idx] <= wgt_in;
                        wgt_idx    <= wgt_idx + IW'(1);
                        if (wgt_idx == WGT_LAST) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (ifm_fire) begin
                        win     <= new_win;
                        acc_cnt <= acc_cnt + AW'(1);
                        // The window is full once the KERNEL_SIZE-th sample arrives.
                        if (acc_cnt >= FIRST_OUT) begin
                            pending   <= 1'b1;
                            pend_data <= result;
                        end
                        if (acc_cnt == ROW_LAST) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!pending && (count == '0)) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_row_engine.sv
// Self-checking bench for conv_row_engine: a cycle-level behavioural model built from
// the row/window arithmetic, compared every cycle, plus literal checks of known rows.
module tb_conv_row_engine;
  localparam int K         = 3;
  localparam int IW        = 8;
  localparam int WW        = 8;
  localparam int DW        = 16;
  localparam int ROW_LEN   = 16;
  localparam int OUT_DEPTH = 4;
  localparam int N_OUT     = ROW_LEN - K + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          reuse_wgt;
  logic          wgt_valid;
  logic          wgt_ready;
  logic [WW-1:0] wgt_in;
  logic          ifm_valid;
  logic          ifm_ready;
  logic [IW-1:0] ifm_in;
  logic [DW-1:0] psum_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic [1:0]    fsm_state;

  int checks = 0;
  int errors = 0;
  int sent = 0;
  int ready_mode = 0;

  // Behavioural model: phase 0 idle, 1 loading weights, 2 streaming, 3 draining.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_q[$];
  logic [IW-1:0] m_samp[$];
  logic [WW-1:0] m_w[K];
  int m_phase;
  int m_widx;
  int m_acc;
  bit m_pending;
  bit m_done;

  conv_row_engine #(
    .KERNEL_SIZE(K), .IFM_WIDTH(IW), .WEIGHT_WIDTH(WW),
    .DATA_WIDTH(DW), .ROW_LEN(ROW_LEN), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reuse_wgt(reuse_wgt),
    .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt_in(wgt_in),
    .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_in(ifm_in),
    .psum_in(psum_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_phase   = 0;
    m_widx    = 0;
    m_acc     = 0;
    m_pending = 0;
    m_done    = 0;
    for (int k = 0; k < K; k++) m_w[k] = '0;
    m_samp.delete();
    exp_q.delete();
  endfunction

  // ---------------- compare + model update (away from the active edge) ----------------
  always @(negedge clk) begin
    int fifo_n;
    bit e_out_valid;
    bit e_ifm_ready;
    bit new_pend;
    bit new_done;
    longint s;

    fifo_n      = exp_q.size() - int'(m_pending);
    e_out_valid = (fifo_n > 0);
    e_ifm_ready = (m_phase == 2) && (m_acc < ROW_LEN) && (exp_q.size() < OUT_DEPTH);

    check("busy", busy, m_phase != 0);
    check("done", done, m_done);
    check("wgt_ready", wgt_ready, m_phase == 1);
    check("ifm_ready", ifm_ready, e_ifm_ready);
    check("out_valid", out_valid, e_out_valid);
    if (e_out_valid) check("out_data", out_data, exp_q[0]);

    if (out_valid && out_ready) obs_q.push_back(out_data);

    if (!rst_n) begin
      model_reset();
    end else begin
      new_pend = 0;
      new_done = 0;
      if (e_out_valid && out_ready) void'(exp_q.pop_front());
      case (m_phase)
        0: if (start) begin
          m_acc = 0;
          m_samp.delete();
          m_widx = 0;
          m_phase = reuse_wgt ? 2 : 1;
        end
        1: if (wgt_valid) begin
          m_w[m_widx] = wgt_in;
          m_widx++;
          if (m_widx == K) m_phase = 2;
        end
        2: if (ifm_valid && e_ifm_ready) begin
          m_samp.push_back(ifm_in);
          m_acc++;
          if (m_acc >= K) begin
            s = psum_in;
            for (int k = 0; k < K; k++) s += longint'(m_w[k]) * longint'(m_samp[m_acc - K + k]);
            exp_q.push_back(DW'(s));
            new_pend = 1;
          end
          if (m_acc == ROW_LEN) m_phase = 3;
        end
        default: if (!m_pending && fifo_n == 0) begin
          new_done = 1;
          m_phase = 0;
        end
      endcase
      m_pending = new_pend;
      m_done    = new_done;
    end
  end

  // ---------------- sink backpressure ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_row(input bit reuse);
    @(posedge clk);
    #1;
    start = 1'b1;
    reuse_wgt = reuse;
    @(posedge clk);
    #1;
    start = 1'b0;
    reuse_wgt = 1'($urandom_range(0, 1));
    obs_q.delete();
  endtask

  task automatic send_weights(input logic [WW-1:0] wv[$]);
    int n = 0;
    int guard = 0;
    while (n < K && guard < 200) begin
      @(posedge clk);
      #1;
      wgt_valid = ($urandom_range(0, 3) != 0);
      wgt_in = wgt_valid ? wv[n] : WW'($urandom);
      @(negedge clk);
      if (wgt_valid && wgt_ready) n++;
      guard++;
    end
    @(posedge clk);
    #1;
    wgt_valid = 1'b0;
    check("wgt_handshakes", n, K);
  endtask

  task automatic send_samples(input logic [IW-1:0] smp[$], input logic [DW-1:0] psum,
                              input bit psum_rand, input int limit);
    int guard = 0;
    sent = 0;
    while (sent < limit && guard < 2000) begin
      @(posedge clk);
      #1;
      ifm_valid = ($urandom_range(0, 3) != 0);
      ifm_in = smp[sent];
      psum_in = psum_rand ? DW'($urandom) : psum;
      @(negedge clk);
      if (ifm_valid && ifm_ready) sent++;
      guard++;
    end
    @(posedge clk);
    #1;
    ifm_valid = 1'b0;
    check("samples_sent", sent, limit);
  endtask

  task automatic wait_done();
    int n = 0;
    bit seen = 0;
    while (!seen && n < 400) begin
      @(negedge clk);
      if (done) seen = 1;
      n++;
    end
    check("done_seen", seen, 1);
    if (seen) check("busy_at_done", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_wgt_ready"}, wgt_ready, 0);
    check({tag, "_ifm_ready"}, ifm_ready, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [IW-1:0] smp[$];
    logic [WW-1:0] wv[$];
    bit reuse;

    rst_n = 1'b0; start = 1'b0; reuse_wgt = 1'b0;
    wgt_valid = 1'b0; wgt_in = '0; ifm_valid = 1'b0; ifm_in = '0; psum_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Known row: w=1,2,3, bias 5, ramp 1..16.
    ready_mode = 0;
    wv = '{8'd1, 8'd2, 8'd3};
    smp.delete();
    for (int i = 0; i < ROW_LEN; i++) smp.push_back(IW'(i + 1));
    start_row(0);
    send_weights(wv);
    send_samples(smp, 16'd5, 0, ROW_LEN);
    wait_done();
    check("ramp_count", obs_q.size(), N_OUT);
    if (obs_q.size() == N_OUT) begin
      check("ramp_first", obs_q[0], 19);
      check("ramp_second", obs_q[1], 25);
      check("ramp_last", obs_q[N_OUT - 1], 97);
    end

    // Same row with the sink stalled: FIFO fills, input stalls, then drains in order.
    ready_mode = 1;
    start_row(1);
    fork
      send_samples(smp, 16'd5, 0, ROW_LEN);
      begin
        repeat (40) @(negedge clk);
        check("stall_accepted", sent, 6);
        check("stall_ifm_ready", ifm_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_head", out_data, 19);
        ready_mode = 0;
      end
    join
    wait_done();
    check("stall_count", obs_q.size(), N_OUT);
    for (int i = 0; i < obs_q.size(); i++) check("stall_order", obs_q[i], 19 + 6 * i);

    // Reused weights, constant input 2, no bias.
    smp.delete();
    for (int i = 0; i < ROW_LEN; i++) smp.push_back(IW'(2));
    start_row(1);
    send_samples(smp, 16'd0, 0, ROW_LEN);
    wait_done();
    check("twos_count", obs_q.size(), N_OUT);
    for (int i = 0; i < obs_q.size(); i++) check("twos_value", obs_q[i], 12);

    // Full-scale weights and samples: result wraps modulo 2^16.
    wv = '{8'd255, 8'd255, 8'd255};
    smp.delete();
    for (int i = 0; i < ROW_LEN; i++) smp.push_back(IW'(255));
    start_row(0);
    send_weights(wv);
    send_samples(smp, 16'd0, 0, ROW_LEN);
    wait_done();
    check("wrap_count", obs_q.size(), N_OUT);
    for (int i = 0; i < obs_q.size(); i++) check("wrap_value", obs_q[i], 64003);

    // Random rows with random backpressure, per-cycle bias, and a stray start mid-row.
    for (int r = 0; r < 6; r++) begin
      ready_mode = 2;
      reuse = (r == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      wv.delete();
      for (int k = 0; k < K; k++) wv.push_back(WW'($urandom));
      smp.delete();
      for (int i = 0; i < ROW_LEN; i++) smp.push_back(IW'($urandom));
      start_row(reuse);
      if (!reuse) send_weights(wv);
      fork
        send_samples(smp, 16'd0, 1, ROW_LEN);
        begin
          repeat (6) @(posedge clk);
          #1;
          start = 1'b1;
          reuse_wgt = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
          start = 1'b0;
        end
      join
      wait_done();
      check("rand_count", obs_q.size(), N_OUT);
    end

    // Reset mid-row, then a row with the cleared weights yields just the bias.
    ready_mode = 0;
    smp.delete();
    for (int i = 0; i < ROW_LEN; i++) smp.push_back(IW'($urandom));
    start_row(1);
    send_samples(smp, 16'd9, 0, 8);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrow_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_row(1);
    send_samples(smp, 16'd77, 0, ROW_LEN);
    wait_done();
    check("zero_w_count", obs_q.size(), N_OUT);
    for (int i = 0; i < obs_q.size(); i++) check("zero_w_value", obs_q[i], 77);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
